mlp_p_neuron_engine: RTL

//  Time-multiplexed MLP inference engine with P parallel neuron units (P=1: one-neuron, P=N: fully parallel).

---
 rtl/mlp_pkg.sv | 42 ++++
 rtl/mlp_mac_unit.sv | 62 ++++++
 rtl/mlp_p_neuron_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and width/saturation helpers for the MLP neuron engine.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACT_NONE     = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LEAKY    = 2'd2,
    ACT_NONE_ALT = 2'd3
  } act_mode_e;

  // Negative slope of the leaky ReLU is 2^-LEAKY_SHIFT.
  localparam int LEAKY_SHIFT = 3;

  // Accumulator must hold N products plus the aligned bias without overflow.
  function automatic int acc_width(input int d, input int wd, input int n);
    return d + wd + $clog2(n + 1);
  endfunction

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Clamp a wide signed value to the d-bit two's complement range.
  function automatic logic signed [63:0] sat_d(input logic signed [63:0] v, input int d);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (d - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (d - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// One neuron unit: bias preload, multiply-accumulate, then requantise,
// saturate and apply the selected activation to the accumulator.
module mlp_mac_unit
  import mlp_pkg::*;
#(
  parameter int D  = 8,
  parameter int WD = 8,
  parameter int QN = 5,
  parameter int WN = 5,
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 load,
  input  logic                 en,
  input  logic signed [WD-1:0] bias,
  input  logic signed [D-1:0]  act,
  input  logic signed [WD-1:0] weight,
  input  act_mode_e            mode,
  output logic signed [D-1:0]  result
);

  logic signed [D+WD-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   bias_ext;
  logic signed [AW-1:0]   acc_reg;
  logic signed [AW-1:0]   acc_shift;
  logic signed [63:0]     shift_wide;
  logic signed [D-1:0]    sat_val;

  // Product carries QN+WN fraction bits; the bias is moved onto the same grid.
  assign prod      = (D+WD)'(act) * (D+WD)'(weight);
  assign prod_ext  = AW'(prod);
  assign bias_ext  = AW'(bias) <<< QN;

  // Drop the weight fraction bits (floor) and clamp to the data range.
  assign acc_shift  = acc_reg >>> WN;
  assign shift_wide = 64'(acc_shift);
  assign sat_val    = D'(sat_d(shift_wide, D));

  // Accumulator: bias preload has priority over accumulation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= bias_ext;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

  // Activation on the saturated value; leaky keeps the floor of x/8.
  always_comb begin
    result = sat_val;
    case (mode)
      ACT_RELU:  if (sat_val < 0) result = '0;
      ACT_LEAKY: if (sat_val < 0) result = sat_val >>> LEAKY_SHIFT;
      default:   result = sat_val;
    endcase
  end

endmodule

// File: rtl/mlp_p_neuron_engine.sv
// Time-multiplexed MLP inference engine: P neuron units sweep the N neurons
// of each of the M-1 layers in groups, ping-ponging between two activation
// buffers, and present the last layer with a valid/ready handshake.
module mlp_p_neuron_engine
  import mlp_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int P  = 1,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [QM+QN-1:0]   x [N],
  input  logic [1:0]                act_mode,
  input  logic signed [WM+WN-1:0]   w [M-1][N][N],
  input  logic signed [WM+WN-1:0]   b [M-1][N],
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [QM+QN-1:0]   outputs [N]
);

  localparam int D  = QM + QN;
  localparam int WD = WM + WN;
  localparam int AW = acc_width(D, WD, N);
  localparam int G  = N / P;
  localparam int NW = idx_width(N);
  localparam int GW = idx_width(G);
  localparam int LW = idx_width(M - 1);

  generate
    if (N % P != 0) begin : g_bad_p
      $error("mlp_p_neuron_engine: N must be a multiple of P");
    end
  endgenerate

  state_e            state_reg;
  act_mode_e         mode_reg;
  logic [LW-1:0]     l_reg;
  logic [LW-1:0]     l_next;
  logic [GW-1:0]     g_reg;
  logic [GW-1:0]     g_next;
  logic [NW-1:0]     k_reg;
  logic              sel_reg;
  logic signed [D-1:0] buf_a_reg [N];
  logic signed [D-1:0] buf_b_reg [N];
  logic signed [D-1:0] wr_vec    [N];
  logic signed [D-1:0] result    [P];
  logic signed [D-1:0] act_cur;
  logic              accept;
  logic              last_k;
  logic              last_group;
  logic              last_layer;
  logic              mac_load;
  logic              mac_en;
  logic [31:0]       base;
  logic [31:0]       base_next;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_k     = (k_reg == NW'(N - 1));
  assign last_group = (g_reg == GW'(G - 1));
  assign last_layer = (l_reg == LW'(M - 2));
  assign mac_load   = accept || (state_reg == WRITE);
  assign mac_en     = (state_reg == MAC);
  assign base       = 32'(g_reg) * 32'(P);
  assign base_next  = 32'(g_next) * 32'(P);

  // sel_reg=0 reads layer input from buffer A and writes results into B.
  assign act_cur = sel_reg ? buf_b_reg[k_reg] : buf_a_reg[k_reg];

  // Layer/group that the next bias preload belongs to.
  always_comb begin
    g_next = '0;
    l_next = '0;
    if (state_reg != IDLE) begin
      if (!last_group) begin
        g_next = g_reg + GW'(1);
        l_next = l_reg;
      end else if (!last_layer) begin
        l_next = l_reg + LW'(1);
      end else begin
        l_next = l_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_unit
      logic [NW-1:0] row;
      logic [NW-1:0] row_next;
      assign row      = NW'(base + 32'(gi));
      assign row_next = NW'(base_next + 32'(gi));

      mlp_mac_unit #(
        .D (D),
        .WD(WD),
        .QN(QN),
        .WN(WN),
        .AW(AW)
      ) u_mac (
        .clk   (clk),
        .nrst  (nrst),
        .load  (mac_load),
        .en    (mac_en),
        .bias  (b[l_next][row_next]),
        .act   (act_cur),
        .weight(w[l_reg][row][k_reg]),
        .mode  (mode_reg),
        .result(result[gi])
      );
    end
  endgenerate

  // Next contents of the write buffer: earlier groups kept, current group replaced.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr_vec[i] = sel_reg ? buf_a_reg[i] : buf_b_reg[i];
    end
    for (int p = 0; p < P; p++) begin
      wr_vec[NW'(base + 32'(p))] = result[p];
    end
  end

  // Control FSM with counters and registered handshake outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      mode_reg  <= ACT_NONE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      l_reg     <= '0;
      g_reg     <= '0;
      k_reg     <= '0;
      sel_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= MAC;
            mode_reg  <= act_mode_e'(act_mode);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            l_reg     <= '0;
            g_reg     <= '0;
            k_reg     <= '0;
            sel_reg   <= 1'b0;
          end
        end
        MAC: begin
          if (last_k) begin
            k_reg     <= '0;
            state_reg <= WRITE;
          end else begin
            k_reg <= k_reg + NW'(1);
          end
        end
        WRITE: begin
          k_reg <= '0;
          g_reg <= g_next;
          l_reg <= l_next;
          if (last_group && last_layer) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            if (last_group) sel_reg <= ~sel_reg;
            state_reg <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Activation buffers and the output register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) begin
        buf_a_reg[i] <= '0;
        buf_b_reg[i] <= '0;
        outputs[i]   <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) buf_a_reg[i] <= x[i];
    end else if (state_reg == WRITE) begin
      for (int i = 0; i < N; i++) begin
        if (sel_reg) buf_a_reg[i] <= wr_vec[i];
        else         buf_b_reg[i] <= wr_vec[i];
      end
      if (last_group && last_layer) begin
        for (int i = 0; i < N; i++) outputs[i] <= wr_vec[i];
      end
    end
  end

endmodule
